// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter among NUM_REQ byte sources.
// It launches one frame per grant and supervises completion with a timeout.
module uart_tx_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 200_000
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [8*NUM_REQ-1:0]       req_data,
    input  logic [NUM_REQ-1:0]         req_mask,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic                       tx_busy,
    input  logic                       tx_done,
    output logic                       tx_start,
    output logic [7:0]                 tx_data,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       frame_done,
    output logic                       timeout_err,
    output logic                       arb_busy
);
    localparam int IDW = $clog2(NUM_REQ);
    localparam int CW  = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, START, WAIT_DONE} state_t;

    state_t           state, state_nxt;
    logic [IDW-1:0]   rr_ptr, grant, idx_w;
    logic [NUM_REQ-1:0] eligible;
    logic [CW-1:0]    cnt;
    logic             found, accept, cnt_last, done_nxt, to_nxt;
    int               idx;

    assign eligible = req_valid & req_mask;

    // Scan upward from rr_ptr+1 with wrap; first eligible index wins.
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = 0;
        idx_w = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            idx_w = IDW'(idx);
            if (!found && eligible[idx_w]) begin
                found = 1'b1;
                grant = idx_w;
            end
        end
    end

    assign accept    = (state == IDLE) && !tx_busy && found;
    assign req_ready = accept ? (NUM_REQ'(1) << grant) : '0;
    assign tx_start  = (state == START);
    assign arb_busy  = (state != IDLE);
    assign cnt_last  = (cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Completion wins over a timeout landing on the same cycle.
    always_comb begin
        state_nxt = state;
        done_nxt  = 1'b0;
        to_nxt    = 1'b0;
        case (state)
            IDLE:      if (accept) state_nxt = START;
            START:     state_nxt = WAIT_DONE;
            WAIT_DONE: begin
                if (tx_done) begin
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
                end else if (cnt_last) begin
                    to_nxt    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default:   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr      <= IDW'(NUM_REQ - 1);
            tx_data     <= '0;
            grant_id    <= '0;
            cnt         <= '0;
            frame_done  <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            frame_done  <= done_nxt;
            timeout_err <= to_nxt;
            if (accept) begin
                tx_data  <= req_data[{grant, 3'b000} +: 8];
                grant_id <= grant;
                rr_ptr   <= grant;
            end
            if (state == START)          cnt <= '0;
            else if (state == WAIT_DONE) cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: stimulus queues expected tx_start /
// frame_done / timeout_err events with their cycle; a monitor pops and compares.
module tb_uart_tx_arbiter;
    localparam int EV_START = 0, EV_DONE = 1, EV_TO = 2;

    typedef struct {
        int         kind;
        logic [7:0] data;
        logic [1:0] id;
        int         at;
    } exp_t;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic [3:0]  req_valid = '0, req_mask = 4'b1111, req_ready;
    logic [31:0] req_data = '0;
    logic        tx_busy = 1'b0, tx_done = 1'b0;
    logic        tx_start, frame_done, timeout_err, arb_busy;
    logic [7:0]  tx_data;
    logic [1:0]  grant_id;

    int   cyc = 0;
    int   vectors = 0, miscompares = 0;
    exp_t sb[$];

    uart_tx_arbiter #(.NUM_REQ(4), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
        .req_mask(req_mask), .req_ready(req_ready), .tx_busy(tx_busy),
        .tx_done(tx_done), .tx_start(tx_start), .tx_data(tx_data),
        .grant_id(grant_id), .frame_done(frame_done), .timeout_err(timeout_err),
        .arb_busy(arb_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        vectors++;
        if (act !== exp_v) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    task automatic push(input int kind, input logic [7:0] data, input logic [1:0] id, input int at);
        exp_t e;
        e.kind = kind; e.data = data; e.id = id; e.at = at;
        sb.push_back(e);
    endtask

    task automatic ev_chk(input int kind);
        exp_t e;
        vectors++;
        if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_event: got kind %0d at cycle %0d, expected none", kind, cyc);
        end else begin
            e = sb.pop_front();
            if (e.kind != kind || e.at != cyc || tx_data !== e.data || grant_id !== e.id) begin
                miscompares++;
                $display("FAIL event: got kind %0d cyc %0d data %0h id %0d, expected kind %0d cyc %0d data %0h id %0d",
                         kind, cyc, tx_data, grant_id, e.kind, e.at, e.data, e.id);
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (tx_start)    ev_chk(EV_START);
            if (frame_done)  ev_chk(EV_DONE);
            if (timeout_err) ev_chk(EV_TO);
        end
    end

    task automatic goto(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        goto(cyc + 2);
        rst_n = 1'b1;
    endtask

    initial begin
        int c, r, s, id;
        #1;
        chk("rst_arb_busy", arb_busy, 0);
        chk("rst_tx_start", tx_start, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_grant_id", grant_id, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_timeout_err", timeout_err, 0);
        goto(2);
        rst_n = 1'b1;

        // Single request, with a stray tx_done in IDLE first
        tx_done = 1'b1;
        goto(cyc + 1);
        tx_done = 1'b0;
        c = cyc;
        req_valid = 4'b0100; req_data = 32'h00A5_0000;
        #3 chk("single_ready", req_ready, 4'b0100);
        push(EV_START, 8'hA5, 2, c + 1);
        goto(c + 1); req_valid = '0;
        goto(c + 2); tx_done = 1'b1; push(EV_DONE, 8'hA5, 2, c + 3);
        goto(c + 3); tx_done = 1'b0;
        goto(c + 5);

        // Round robin with all four held valid
        do_reset();
        c = cyc;
        req_valid = 4'b1111; req_data = 32'hD3C2_B1A0;
        for (int k = 0; k < 5; k++) begin
            id = k % 4;
            s  = c + 1 + 7 * k;
            push(EV_START, 8'hA0 + 8'(8'h11 * id), 2'(id), s);
            push(EV_DONE,  8'hA0 + 8'(8'h11 * id), 2'(id), s + 6);
        end
        for (int k = 0; k < 5; k++) begin
            s = c + 1 + 7 * k;
            if (k == 4) begin goto(s + 1); req_valid = '0; end
            goto(s + 5); tx_done = 1'b1;
            goto(s + 6); tx_done = 1'b0;
        end
        goto(cyc + 2);

        // Mask excludes index 0
        do_reset();
        c = cyc;
        req_valid = 4'b0011; req_mask = 4'b1110; req_data = 32'h0000_6655;
        #3 chk("mask_ready", req_ready, 4'b0010);
        push(EV_START, 8'h66, 1, c + 1);
        goto(c + 1); req_valid = 4'b0001;
        #3 chk("mask_start_ready", req_ready, 0);
        goto(c + 3); tx_done = 1'b1; push(EV_DONE, 8'h66, 1, c + 4);
        goto(c + 4); tx_done = 1'b0;
        #3 chk("mask_idle_ready", req_ready, 0);
        chk("mask_idle_busy", arb_busy, 0);
        goto(c + 6);
        #3 chk("mask_idle_ready2", req_ready, 0);
        req_valid = '0; req_mask = 4'b1111;

        // Timeout with no tx_done
        do_reset();
        c = cyc;
        req_valid = 4'b0001; req_data = 32'h0000_00C3;
        push(EV_START, 8'hC3, 0, c + 1);
        push(EV_TO,    8'hC3, 0, c + 18);
        goto(c + 1); req_valid = '0;
        goto(c + 17); chk("to_busy_before", arb_busy, 1);
        goto(c + 18); chk("to_busy_after", arb_busy, 0);
        goto(c + 20);

        // Busy gate, then tx_done on the terminal count
        do_reset();
        c = cyc;
        tx_busy = 1'b1; req_valid = 4'b0001; req_data = 32'h0000_007E;
        #3 chk("busy_gate_ready", req_ready, 0);
        goto(c + 1);
        chk("busy_gate_idle", arb_busy, 0);
        chk("busy_gate_ready2", req_ready, 0);
        tx_busy = 1'b0;
        #3 chk("busy_release_ready", req_ready, 4'b0001);
        push(EV_START, 8'h7E, 0, c + 2);
        goto(c + 2); req_valid = '0;
        goto(c + 18); tx_done = 1'b1; push(EV_DONE, 8'h7E, 0, c + 19);
        goto(c + 19); tx_done = 1'b0;
        goto(c + 22);

        // Reset in the middle of a frame
        do_reset();
        c = cyc;
        req_valid = 4'b0100; req_data = 32'h005A_0000;
        push(EV_START, 8'h5A, 2, c + 1);
        goto(c + 1); req_valid = '0;
        goto(c + 4);
        chk("midrst_busy_pre", arb_busy, 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_arb_busy", arb_busy, 0);
        chk("midrst_tx_start", tx_start, 0);
        chk("midrst_tx_data", tx_data, 0);
        chk("midrst_grant_id", grant_id, 0);
        chk("midrst_frame_done", frame_done, 0);
        chk("midrst_timeout_err", timeout_err, 0);
        chk("midrst_req_ready", req_ready, 0);
        req_valid = 4'b1001; req_data = 32'h9900_0011;
        goto(c + 6);
        rst_n = 1'b1;
        r = cyc;
        #3 chk("midrst_prio_ready", req_ready, 4'b0001);
        push(EV_START, 8'h11, 0, r + 1);
        goto(r + 1); req_valid = '0;
        goto(r + 3); tx_done = 1'b1; push(EV_DONE, 8'h11, 0, r + 4);
        goto(r + 4); tx_done = 1'b0;
        goto(r + 8);

        chk("sb_drain", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish by cycle %0d, expected finish", cyc);
        $fatal(1);
    end
endmodule
